// File: rtl/fan_pwm_driver_pkg.sv
// ----------------------------------------------------------------------------
// fan_pkg
//   Shared types and constants for the fan PWM driver.
//   - fan_state_e       : driver FSM states (IDLE, KICK, RUN)
//   - VEL_*             : the four speed patterns the upstream encoder emits
//   - KICK_PAT          : all-ones soft-start pattern
//   - FRAME_SLOTS/BIT_W : bit slots per frame and width of the slot index
//   - effective_pattern : the pattern that a given state plays on the fan line
// ----------------------------------------------------------------------------
package fan_pkg;

    localparam int FRAME_SLOTS = 8;
    localparam int BIT_W       = $clog2(FRAME_SLOTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2
    } fan_state_e;

    localparam logic [FRAME_SLOTS-1:0] VEL_OFF  = 8'h00;
    localparam logic [FRAME_SLOTS-1:0] VEL_1    = 8'h0F;
    localparam logic [FRAME_SLOTS-1:0] VEL_2    = 8'h33;
    localparam logic [FRAME_SLOTS-1:0] VEL_3    = 8'hC3;
    localparam logic [FRAME_SLOTS-1:0] KICK_PAT = 8'hFF;

    // Pattern played on the fan line for a given state. In RUN the
    // latched commanded pattern is used; the other states have fixed ones.
    function automatic logic [FRAME_SLOTS-1:0] effective_pattern(
        input fan_state_e             st,
        input logic [FRAME_SLOTS-1:0] active
    );
        logic [FRAME_SLOTS-1:0] pat;
        pat = VEL_OFF;
        case (st)
            IDLE:    pat = VEL_OFF;
            KICK:    pat = KICK_PAT;
            RUN:     pat = active;
            default: pat = VEL_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/fan_pwm_driver_if.sv
// ----------------------------------------------------------------------------
// fan_pwm_driver_if
//   Bundle between the speed encoder (master) and the fan PWM driver (slave).
//   Signals:
//     vel_in     : commanded speed pattern (master -> slave)
//     fan_out    : serialised fan drive bit (slave -> master)
//     frame_tick : one-cycle pulse at the start of each frame
//     kicking    : high while the driver plays soft-start frames
//     vel_active : pattern currently played in RUN, zero otherwise
// ----------------------------------------------------------------------------
interface fan_pwm_driver_if #(
    parameter int PAT_W = 8
);

    logic [PAT_W-1:0] vel_in;
    logic             fan_out;
    logic             frame_tick;
    logic             kicking;
    logic [PAT_W-1:0] vel_active;

    modport master (
        output vel_in,
        input  fan_out,
        input  frame_tick,
        input  kicking,
        input  vel_active
    );

    modport slave (
        input  vel_in,
        output fan_out,
        output frame_tick,
        output kicking,
        output vel_active
    );

endinterface

// File: rtl/fan_pwm_driver_slot_timer.sv
// ----------------------------------------------------------------------------
// fan_slot_timer
//   Free-running time base for the fan driver: a prescaler that divides the
//   clock into bit slots of PRESC_DIV cycles and a slot index that walks
//   through the FRAME_SLOTS slots of a frame.
//   Ports:
//     clk           : system clock
//     rst           : synchronous active-high reset (counters to zero)
//     bit_idx_o     : current slot index within the frame
//     slot_tick_o   : high on the last cycle of a slot (prescaler wraps)
//     frame_end_o   : high on the last cycle of a frame (frame boundary edge)
//     frame_start_o : registered one-cycle pulse in the first cycle of a
//                     frame; never set in the first cycle after reset
// ----------------------------------------------------------------------------
module fan_slot_timer
    import fan_pkg::*;
#(
    parameter int PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [BIT_W-1:0] bit_idx_o,
    output logic             slot_tick_o,
    output logic             frame_end_o,
    output logic             frame_start_o
);

    // A divide-by-one prescaler still gets a one-bit counter that stays 0.
    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_SLOTS - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [BIT_W-1:0]   bit_idx_q;
    logic               frame_start_q;

    assign slot_tick_o   = (presc_q == PRESC_LAST);
    assign frame_end_o   = slot_tick_o && (bit_idx_q == BIT_LAST);
    assign bit_idx_o     = bit_idx_q;
    assign frame_start_o = frame_start_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            bit_idx_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            if (slot_tick_o) begin
                presc_q   <= '0;
                // FRAME_SLOTS is a power of two, so the index wraps by itself.
                bit_idx_q <= bit_idx_q + BIT_W'(1);
            end else begin
                presc_q   <= presc_q + PRESC_W'(1);
            end
            // The cycle after a boundary edge is slot 0 / presc 0.
            frame_start_q <= frame_end_o;
        end
    end

endmodule

// File: rtl/fan_pwm_driver.sv
// ----------------------------------------------------------------------------
// fan_pwm_driver
//   Serialises the 8-bit speed pattern from the encoder onto the fan drive
//   line, LSB first, one bit per slot. Patterns only change on frame
//   boundaries; a fan started from rest is first given KICK_FRAMES all-ones
//   frames.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset; stops the fan on the reset edge
//     bus  : fan_pwm_driver_if slave modport
//            (vel_in in; fan_out, frame_tick, kicking, vel_active out)
//   All outputs come straight from flops.
// ----------------------------------------------------------------------------
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int PRESC_DIV   = 4,
    parameter int KICK_FRAMES = 2,
    parameter int PAT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    fan_pwm_driver_if.slave   bus
);

    localparam int KICK_W = (KICK_FRAMES > 1) ? $clog2(KICK_FRAMES) : 1;
    localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    logic [BIT_W-1:0] bit_idx;
    logic             slot_tick;
    logic             frame_end;
    logic             frame_start;

    fan_slot_timer #(
        .PRESC_DIV (PRESC_DIV)
    ) u_slot_timer (
        .clk           (clk),
        .rst           (rst),
        .bit_idx_o     (bit_idx),
        .slot_tick_o   (slot_tick),
        .frame_end_o   (frame_end),
        .frame_start_o (frame_start)
    );

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    fan_state_e        state_q,      state_d;
    logic [KICK_W-1:0] kick_cnt_q,   kick_cnt_d;
    logic [PAT_W-1:0]  vel_active_q, vel_active_d;
    logic              fan_out_q,    fan_out_d;
    logic              kicking_q;

    logic                   vel_nz;
    logic [BIT_W-1:0]       bit_idx_d;
    logic [FRAME_SLOTS-1:0] eff_pat_d;
    logic [FRAME_SLOTS-1:0] slot_sel;

    assign vel_nz = |bus.vel_in;

    // Next-state decisions are taken only on the frame boundary edge, so a
    // frame always completes with the pattern it started with.
    always_comb begin
        state_d      = state_q;
        kick_cnt_d   = kick_cnt_q;
        vel_active_d = vel_active_q;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (vel_nz) begin
                        state_d    = KICK;
                        kick_cnt_d = '0;
                    end
                end
                KICK: begin
                    if (!vel_nz) begin
                        // Command withdrawn during soft start: abort the kick.
                        state_d = IDLE;
                    end else if (kick_cnt_q == KICK_LAST) begin
                        state_d      = RUN;
                        vel_active_d = bus.vel_in;
                    end else begin
                        kick_cnt_d = kick_cnt_q + KICK_W'(1);
                    end
                end
                RUN: begin
                    if (!vel_nz) begin
                        state_d      = IDLE;
                        vel_active_d = '0;
                    end else begin
                        // Pattern changes while running never re-kick.
                        vel_active_d = bus.vel_in;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    vel_active_d = '0;
                end
            endcase
        end
    end

    // The output flop is loaded with the bit of the *next* slot under the
    // *next* state, so fan_out, bit_idx and state all change on one edge.
    assign bit_idx_d = slot_tick ? (bit_idx + BIT_W'(1)) : bit_idx;
    assign eff_pat_d = effective_pattern(state_d, vel_active_d);

    // One-hot slot decode; the bit select is an AND-OR of the pattern.
    generate
        for (genvar gi = 0; gi < FRAME_SLOTS; gi++) begin : g_slot_sel
            assign slot_sel[gi] = (bit_idx_d == BIT_W'(gi));
        end
    endgenerate

    assign fan_out_d = |(eff_pat_d & slot_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            kick_cnt_q   <= '0;
            vel_active_q <= '0;
            fan_out_q    <= 1'b0;
            kicking_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            kick_cnt_q   <= kick_cnt_d;
            vel_active_q <= vel_active_d;
            fan_out_q    <= fan_out_d;
            kicking_q    <= (state_d == KICK);
        end
    end

    assign bus.fan_out    = fan_out_q;
    assign bus.kicking    = kicking_q;
    assign bus.vel_active = vel_active_q;
    assign bus.frame_tick = frame_start;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// ----------------------------------------------------------------------------
// tb_fan_pwm_driver
//   Two driver instances: A (PRESC_DIV=4, KICK_FRAMES=2) and
//   B (PRESC_DIV=1, KICK_FRAMES=1). A frame-level reference model tracks the
//   cycle count since reset and the pattern chosen for each frame; every
//   cycle all outputs of both instances are compared against it.
// ----------------------------------------------------------------------------
module tb_fan_pwm_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    fan_pwm_driver_if #(.PAT_W(8)) bus_a ();
    fan_pwm_driver_if #(.PAT_W(8)) bus_b ();

    fan_pwm_driver #(
        .PRESC_DIV   (4),
        .KICK_FRAMES (2),
        .PAT_W       (8)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    fan_pwm_driver #(
        .PRESC_DIV   (1),
        .KICK_FRAMES (1),
        .PAT_W       (8)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per instance, cycles since reset and frame mode.
    // mode: 0 = stopped, 1 = soft-start, 2 = running
    // ------------------------------------------------------------------
    int         cyc    [2];
    int         mode   [2];
    int         kicks  [2];
    logic [7:0] act    [2];
    bit         valid  [2];

    function automatic int pdiv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int kframes(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_edge(input int i, input logic r, input logic [7:0] v);
        if (r) begin
            cyc[i]   = 0;
            mode[i]  = 0;
            kicks[i] = 0;
            act[i]   = 8'h00;
            valid[i] = 1'b1;
        end else if (valid[i]) begin
            cyc[i]++;
            if (cyc[i] % (8 * pdiv(i)) == 0) begin
                // A new frame begins; decide what it plays.
                if (mode[i] == 0) begin
                    if (v != 0) begin
                        mode[i]  = 1;
                        kicks[i] = 0;
                    end
                end else if (mode[i] == 1) begin
                    if (v == 0) begin
                        mode[i] = 0;
                    end else begin
                        kicks[i]++;
                        if (kicks[i] == kframes(i)) begin
                            mode[i] = 2;
                            act[i]  = v;
                        end
                    end
                end else begin
                    if (v == 0) begin
                        mode[i] = 0;
                        act[i]  = 8'h00;
                    end else begin
                        act[i] = v;
                    end
                end
            end
        end
    endtask

    task automatic compare(input int i, input logic g_fan, input logic g_tick,
                           input logic g_kick, input logic [7:0] g_vact);
        int         pos;
        logic [7:0] pat;
        string      nm;
        nm  = (i == 0) ? "A" : "B";
        pos = cyc[i] % (8 * pdiv(i));
        pat = (mode[i] == 0) ? 8'h00 : (mode[i] == 1) ? 8'hFF : act[i];
        check_eq($sformatf("%s fan_out c%0d", nm, cyc[i]), 32'(g_fan), 32'(pat[pos / pdiv(i)]));
        check_eq($sformatf("%s frame_tick c%0d", nm, cyc[i]), 32'(g_tick),
                 32'((pos == 0) && (cyc[i] != 0)));
        check_eq($sformatf("%s kicking c%0d", nm, cyc[i]), 32'(g_kick), 32'(mode[i] == 1));
        check_eq($sformatf("%s vel_active c%0d", nm, cyc[i]), 32'(g_vact),
                 32'((mode[i] == 2) ? act[i] : 8'h00));
    endtask

    // One clock: capture the inputs the DUT is about to sample, advance the
    // model across the edge, then compare just after the edge.
    task automatic tick();
        logic       ra;
        logic       rb;
        logic [7:0] va;
        logic [7:0] vb;
        ra = rst_a;
        rb = rst_b;
        va = bus_a.vel_in;
        vb = bus_b.vel_in;
        @(posedge clk);
        model_edge(0, ra, va);
        model_edge(1, rb, vb);
        #1;
        if (valid[0]) compare(0, bus_a.fan_out, bus_a.frame_tick, bus_a.kicking, bus_a.vel_active);
        if (valid[1]) compare(1, bus_b.fan_out, bus_b.frame_tick, bus_b.kicking, bus_b.vel_active);
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    // Advance instance A until it sits at frame cycle pos (at least one tick).
    task automatic align_a(input int pos);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (cyc[0] % 32 == pos) begin
                found = 1'b1;
                break;
            end
        end
        check_eq($sformatf("A align pos %0d", pos), 32'(found), 32'd1);
    endtask

    function automatic logic [7:0] pick_vel();
        logic [7:0] v;
        case ($urandom_range(0, 3))
            0:       v = 8'h00;
            1:       v = 8'h0F;
            2:       v = 8'h33;
            default: v = 8'hC3;
        endcase
        return v;
    endfunction

    initial begin
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.vel_in = 8'h0F;
        bus_b.vel_in = 8'h33;
        step(3);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Startup: idle frame, two kick frames, then 0x0F.
        step(170);

        // Mid-frame change in RUN at frame cycle 10.
        align_a(10);
        bus_a.vel_in = 8'h33;
        step(80);

        // Stop, then restart with 0xC3 (kick again).
        align_a(5);
        bus_a.vel_in = 8'h00;
        bus_b.vel_in = 8'h00;
        step(70);
        bus_a.vel_in = 8'hC3;
        bus_b.vel_in = 8'hC3;
        step(160);

        // Reset for one edge at slot 5 while running 0xC3.
        align_a(20);
        rst_a = 1'b1;
        step(1);
        rst_a = 1'b0;
        step(120);

        // Kick abort: drop the command during the first kick frame.
        bus_a.vel_in = 8'h00;
        step(70);
        bus_a.vel_in = 8'h0F;
        align_a(0);
        step(10);
        bus_a.vel_in = 8'h00;
        step(60);

        // Randomised phase.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) bus_a.vel_in = pick_vel();
            if ($urandom_range(0, 19) == 0) bus_b.vel_in = pick_vel();
            rst_a = ($urandom_range(0, 599) == 0);
            rst_b = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
